// File: rtl/commit_scheduler.sv
// In-order commit stage: retires the ROB head into the register file,
// hands stores to the LSB and turns mispredicted control flow into a flush.
module commit_scheduler #(
    parameter int XLEN           = 32,
    parameter int REG_CNT_WIDTH  = 5,
    parameter int ROB_SIZE_WIDTH = 3
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      stall,
    input  logic                      rob_head_valid,
    input  logic [ROB_SIZE_WIDTH-1:0] rob_head_id,
    input  logic [1:0]                rob_head_kind,
    input  logic [REG_CNT_WIDTH-1:0]  rob_head_rd,
    input  logic [XLEN-1:0]           rob_head_val,
    input  logic                      rob_head_mispredict,
    input  logic [XLEN-1:0]           rob_head_target_pc,
    input  logic                      lsb_store_done,
    output logic                      commit_pop,
    output logic                      rf_wr_en,
    output logic [REG_CNT_WIDTH-1:0]  rf_wr_rd,
    output logic [XLEN-1:0]           rf_wr_val,
    output logic [ROB_SIZE_WIDTH-1:0] rf_wr_id,
    output logic                      store_commit_req,
    output logic                      flush,
    output logic [XLEN-1:0]           flush_pc,
    output logic [31:0]               commit_count,
    output logic                      busy
);

    localparam logic [1:0] S_RUN        = 2'd0;
    localparam logic [1:0] S_WAIT_STORE = 2'd1;
    localparam logic [1:0] S_DRAIN      = 2'd2;
    localparam logic [1:0] S_FLUSH      = 2'd3;

    localparam logic [1:0] K_REG    = 2'd0;
    localparam logic [1:0] K_STORE  = 2'd1;
    localparam logic [1:0] K_BRANCH = 2'd2;
    localparam logic [1:0] K_JUMP   = 2'd3;

    logic [1:0]                state_q, state_d;
    logic                      wr_en_q, wr_en_d;
    logic [REG_CNT_WIDTH-1:0]  wr_rd_q, wr_rd_d;
    logic [XLEN-1:0]           wr_val_q, wr_val_d;
    logic [ROB_SIZE_WIDTH-1:0] wr_id_q, wr_id_d;
    logic                      req_q, req_d;
    logic                      flush_q, flush_d;
    logic [XLEN-1:0]           flush_pc_q, flush_pc_d;
    logic [31:0]               count_q, count_d;

    logic is_reg, is_store, is_ctrl, writes_rd;
    logic run_go, accept, store_go, store_done, redirect;

    always_comb begin
        is_reg   = 1'b0;
        is_store = 1'b0;
        is_ctrl  = 1'b0;
        unique case (1'b1)
            rob_head_kind == K_REG:    is_reg   = 1'b1;
            rob_head_kind == K_STORE:  is_store = 1'b1;
            rob_head_kind == K_BRANCH: is_ctrl  = 1'b1;
            rob_head_kind == K_JUMP: begin
                is_reg  = 1'b1;
                is_ctrl = 1'b1;
            end
            default: ;
        endcase
    end

    always_comb begin
        run_go     = (state_q == S_RUN) && rob_head_valid && !stall;
        accept     = run_go && !is_store;
        store_go   = run_go && is_store;
        store_done = (state_q == S_WAIT_STORE) && lsb_store_done;
        redirect   = accept && is_ctrl && rob_head_mispredict;
        writes_rd  = accept && is_reg;
    end

    // Gate with rst_n so the ROB never dequeues while reset is held.
    assign commit_pop = rst_n && (accept || store_done);

    always_comb begin
        state_d    = state_q;
        wr_en_d    = 1'b0;
        wr_rd_d    = wr_rd_q;
        wr_val_d   = wr_val_q;
        wr_id_d    = wr_id_q;
        req_d      = req_q;
        flush_d    = 1'b0;
        flush_pc_d = flush_pc_q;
        count_d    = count_q + {31'd0, commit_pop};
        case (state_q)
            S_RUN: begin
                if (store_go) begin
                    state_d = S_WAIT_STORE;
                    req_d   = 1'b1;
                end
                if (writes_rd) begin
                    wr_en_d  = |rob_head_rd;
                    wr_rd_d  = rob_head_rd;
                    wr_val_d = rob_head_val;
                    wr_id_d  = rob_head_id;
                end
                if (redirect) begin
                    state_d    = S_DRAIN;
                    flush_pc_d = rob_head_target_pc;
                end
            end
            S_WAIT_STORE: begin
                if (lsb_store_done) begin
                    state_d = S_RUN;
                    req_d   = 1'b0;
                end
            end
            // The jump's write lands here, one cycle ahead of the flush.
            S_DRAIN: begin
                state_d = S_FLUSH;
                flush_d = 1'b1;
            end
            S_FLUSH: begin
                state_d = S_RUN;
            end
            default: begin
                state_d = S_RUN;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_RUN;
            wr_en_q    <= 1'b0;
            wr_rd_q    <= '0;
            wr_val_q   <= '0;
            wr_id_q    <= '0;
            req_q      <= 1'b0;
            flush_q    <= 1'b0;
            flush_pc_q <= '0;
            count_q    <= '0;
        end else begin
            state_q    <= state_d;
            wr_en_q    <= wr_en_d;
            wr_rd_q    <= wr_rd_d;
            wr_val_q   <= wr_val_d;
            wr_id_q    <= wr_id_d;
            req_q      <= req_d;
            flush_q    <= flush_d;
            flush_pc_q <= flush_pc_d;
            count_q    <= count_d;
        end
    end

    assign rf_wr_en         = wr_en_q;
    assign rf_wr_rd         = wr_rd_q;
    assign rf_wr_val        = wr_val_q;
    assign rf_wr_id         = wr_id_q;
    assign store_commit_req = req_q;
    assign flush            = flush_q;
    assign flush_pc         = flush_pc_q;
    assign commit_count     = count_q;
    assign busy             = (state_q != S_RUN);

endmodule

// File: tb/tb_commit_scheduler.sv
// Directed bench for commit_scheduler with a cycle-level reference model
// and hand-computed spot checks.
module tb_commit_scheduler;

    localparam int XLEN = 32;
    localparam int RW   = 5;
    localparam int IW   = 3;

    logic            clk;
    logic            rst_n;
    logic            stall;
    logic            rob_head_valid;
    logic [IW-1:0]   rob_head_id;
    logic [1:0]      rob_head_kind;
    logic [RW-1:0]   rob_head_rd;
    logic [XLEN-1:0] rob_head_val;
    logic            rob_head_mispredict;
    logic [XLEN-1:0] rob_head_target_pc;
    logic            lsb_store_done;
    logic            commit_pop;
    logic            rf_wr_en;
    logic [RW-1:0]   rf_wr_rd;
    logic [XLEN-1:0] rf_wr_val;
    logic [IW-1:0]   rf_wr_id;
    logic            store_commit_req;
    logic            flush;
    logic [XLEN-1:0] flush_pc;
    logic [31:0]     commit_count;
    logic            busy;

    int tests = 0;
    int fails = 0;

    commit_scheduler #(
        .XLEN(XLEN), .REG_CNT_WIDTH(RW), .ROB_SIZE_WIDTH(IW)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .stall(stall),
        .rob_head_valid(rob_head_valid),
        .rob_head_id(rob_head_id),
        .rob_head_kind(rob_head_kind),
        .rob_head_rd(rob_head_rd),
        .rob_head_val(rob_head_val),
        .rob_head_mispredict(rob_head_mispredict),
        .rob_head_target_pc(rob_head_target_pc),
        .lsb_store_done(lsb_store_done),
        .commit_pop(commit_pop),
        .rf_wr_en(rf_wr_en),
        .rf_wr_rd(rf_wr_rd),
        .rf_wr_val(rf_wr_val),
        .rf_wr_id(rf_wr_id),
        .store_commit_req(store_commit_req),
        .flush(flush),
        .flush_pc(flush_pc),
        .commit_count(commit_count),
        .busy(busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input logic [63:0] act,
                         input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference model: a store holds commit until done; a redirect
    // blocks two cycles and flushes in the second.
    logic            m_store_wait;
    int              m_redirect;
    logic            m_wr_en;
    logic [RW-1:0]   m_wr_rd;
    logic [XLEN-1:0] m_wr_val;
    logic [IW-1:0]   m_wr_id;
    logic [XLEN-1:0] m_flush_pc;
    logic [31:0]     m_count;

    always @(negedge clk) begin : cmp
        logic ep, eb, ef;
        if (!rst_n) begin
            check("rst_pop", commit_pop, 0);
            check("rst_wr_en", rf_wr_en, 0);
            check("rst_wr_rd", rf_wr_rd, 0);
            check("rst_wr_val", rf_wr_val, 0);
            check("rst_wr_id", rf_wr_id, 0);
            check("rst_req", store_commit_req, 0);
            check("rst_flush", flush, 0);
            check("rst_flush_pc", flush_pc, 0);
            check("rst_count", commit_count, 0);
            check("rst_busy", busy, 0);
            m_store_wait = 0;
            m_redirect   = 0;
            m_wr_en      = 0;
            m_count      = 0;
        end else begin
            if (m_redirect > 0) ep = 0;
            else if (m_store_wait) ep = lsb_store_done;
            else ep = rob_head_valid && !stall && rob_head_kind != 2'd1;
            eb = m_store_wait || (m_redirect > 0);
            ef = (m_redirect == 1);
            check("m_pop", commit_pop, ep);
            check("m_busy", busy, eb);
            check("m_req", store_commit_req, m_store_wait);
            check("m_flush", flush, ef);
            if (ef) check("m_flush_pc", flush_pc, m_flush_pc);
            check("m_wr_en", rf_wr_en, m_wr_en);
            if (m_wr_en) begin
                check("m_wr_rd", rf_wr_rd, m_wr_rd);
                check("m_wr_val", rf_wr_val, m_wr_val);
                check("m_wr_id", rf_wr_id, m_wr_id);
            end
            check("m_count", commit_count, m_count);
            m_wr_en = 0;
            if (m_redirect > 0) begin
                m_redirect--;
            end else if (m_store_wait) begin
                if (lsb_store_done) m_store_wait = 0;
            end else if (rob_head_valid && !stall) begin
                if (rob_head_kind == 2'd1) begin
                    m_store_wait = 1;
                end else begin
                    if (rob_head_kind == 2'd0 || rob_head_kind == 2'd3) begin
                        m_wr_en  = (rob_head_rd != 0);
                        m_wr_rd  = rob_head_rd;
                        m_wr_val = rob_head_val;
                        m_wr_id  = rob_head_id;
                    end
                    if (rob_head_kind[1] && rob_head_mispredict) begin
                        m_redirect = 2;
                        m_flush_pc = rob_head_target_pc;
                    end
                end
            end
            if (ep) m_count = m_count + 1;
        end
    end

    task automatic cyc();
        @(posedge clk);
        #2;
    endtask

    task automatic head(input logic [1:0] kind, input logic [IW-1:0] id,
                        input logic [RW-1:0] rd, input logic [XLEN-1:0] val,
                        input logic mp, input logic [XLEN-1:0] tgt);
        rob_head_valid      = 1'b1;
        rob_head_kind       = kind;
        rob_head_id         = id;
        rob_head_rd         = rd;
        rob_head_val        = val;
        rob_head_mispredict = mp;
        rob_head_target_pc  = tgt;
    endtask

    task automatic idle();
        rob_head_valid      = 1'b0;
        rob_head_mispredict = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0;
        stall = 1'b0;
        lsb_store_done = 1'b0;
        rob_head_id = '0;
        rob_head_kind = '0;
        rob_head_rd = '0;
        rob_head_val = '0;
        rob_head_target_pc = '0;
        idle();
        cyc();
        cyc();
        #1;
        check("reset_busy", busy, 0);
        check("reset_count", commit_count, 0);
        cyc();
        rst_n = 1'b1;
        cyc();

        // Back-to-back register writes
        head(2'd0, 3'd1, 5'd1, 32'd10, 1'b0, 32'd0);
        #1 check("b2b_pop0", commit_pop, 1);
        cyc();
        head(2'd0, 3'd2, 5'd2, 32'd20, 1'b0, 32'd0);
        #1 check("b2b_val1", rf_wr_val, 10);
        check("b2b_pop1", commit_pop, 1);
        cyc();
        head(2'd0, 3'd3, 5'd3, 32'd30, 1'b0, 32'd0);
        #1 check("b2b_rd2", rf_wr_rd, 2);
        cyc();
        idle();
        #1 check("b2b_val3", rf_wr_val, 30);
        check("b2b_count", commit_count, 3);
        cyc();
        #1 check("b2b_wr_off", rf_wr_en, 0);

        // rd = 0 commits without a write
        head(2'd0, 3'd4, 5'd0, 32'd99, 1'b0, 32'd0);
        #1 check("rd0_pop", commit_pop, 1);
        cyc();
        idle();
        #1 check("rd0_wr_en", rf_wr_en, 0);
        check("rd0_count", commit_count, 4);

        // Stall holds the head
        stall = 1'b1;
        head(2'd0, 3'd5, 5'd9, 32'h55, 1'b0, 32'd0);
        #1 check("stall_pop", commit_pop, 0);
        cyc();
        cyc();
        #1 check("stall_count", commit_count, 4);
        stall = 1'b0;
        #1 check("unstall_pop", commit_pop, 1);
        cyc();
        idle();
        #1 check("unstall_rd", rf_wr_rd, 9);
        check("unstall_en", rf_wr_en, 1);

        // Store waits four cycles for the LSB
        head(2'd1, 3'd6, 5'd4, 32'd0, 1'b0, 32'd0);
        #1 check("st_pop_accept", commit_pop, 0);
        cyc();
        for (int i = 0; i < 4; i++) begin
            lsb_store_done = (i == 3);
            #1 check("st_req", store_commit_req, 1);
            check("st_busy", busy, 1);
            check("st_pop", commit_pop, (i == 3));
            check("st_no_wr", rf_wr_en, 0);
            cyc();
        end
        lsb_store_done = 1'b0;
        idle();
        #1 check("st_req_off", store_commit_req, 0);
        check("st_busy_off", busy, 0);
        check("st_count", commit_count, 6);

        // Stray done outside a store is ignored
        lsb_store_done = 1'b1;
        #1 check("stray_done_pop", commit_pop, 0);
        cyc();
        lsb_store_done = 1'b0;

        // Mispredicted jump: write, then flush
        head(2'd3, 3'd2, 5'd5, 32'h104, 1'b1, 32'h200);
        #1 check("jmp_pop", commit_pop, 1);
        cyc();
        head(2'd0, 3'd3, 5'd7, 32'h77, 1'b0, 32'd0);
        #1 check("jmp_wr_en", rf_wr_en, 1);
        check("jmp_wr_rd", rf_wr_rd, 5);
        check("jmp_wr_val", rf_wr_val, 32'h104);
        check("jmp_drain_pop", commit_pop, 0);
        check("jmp_drain_flush", flush, 0);
        cyc();
        #1 check("jmp_flush", flush, 1);
        check("jmp_flush_pc", flush_pc, 32'h200);
        check("jmp_flush_pop", commit_pop, 0);
        check("jmp_flush_wr", rf_wr_en, 0);
        cyc();
        #1 check("jmp_run_busy", busy, 0);
        check("jmp_run_pop", commit_pop, 1);
        cyc();
        idle();
        #1 check("jmp_next_rd", rf_wr_rd, 7);

        // Mispredicted branch flushes without a write
        head(2'd2, 3'd4, 5'd6, 32'h1, 1'b1, 32'h340);
        cyc();
        idle();
        #1 check("br_wr_en", rf_wr_en, 0);
        check("br_busy", busy, 1);
        cyc();
        #1 check("br_flush_pc", flush_pc, 32'h340);
        cyc();
        #1 check("br_flush_off", flush, 0);

        // Mispredict on a register-writing head is ignored
        head(2'd0, 3'd5, 5'd8, 32'h88, 1'b1, 32'h400);
        cyc();
        idle();
        #1 check("mp0_busy", busy, 0);
        check("mp0_wr_val", rf_wr_val, 32'h88);
        cyc();

        // Reset while waiting on a store
        head(2'd1, 3'd6, 5'd0, 32'd0, 1'b0, 32'd0);
        cyc();
        #1 check("rs_req_before", store_commit_req, 1);
        rst_n = 1'b0;
        idle();
        #1 check("rs_req", store_commit_req, 0);
        check("rs_busy", busy, 0);
        check("rs_pop", commit_pop, 0);
        check("rs_count", commit_count, 0);
        cyc();
        cyc();
        rst_n = 1'b1;
        cyc();
        #1 check("rs_run", busy, 0);
        check("rs_no_flush", flush, 0);
        head(2'd0, 3'd1, 5'd3, 32'hab, 1'b0, 32'd0);
        #1 check("rs_pop_after", commit_pop, 1);
        cyc();
        idle();
        #1 check("rs_count_after", commit_count, 1);
        cyc();
        cyc();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/commit_scheduler.md
COMMIT_SCHEDULER -- requirements
Module: commit_scheduler

Interface
REQ-001 The block SHALL have parameter XLEN, default 32, meaning data/PC width.
REQ-002 The block SHALL have parameter REG_CNT_WIDTH, default 5, meaning architectural register index width.
REQ-003 The block SHALL have parameter ROB_SIZE_WIDTH, default 3, meaning ROB entry id width.
REQ-004 The block SHALL have port clk, input, 1 bit: the only clock; all state changes on its rising edge.
REQ-005 The block SHALL have port rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-006 The block SHALL have port stall, input, 1 bit: global hold; when high, no new head is accepted.
REQ-007 The block SHALL have port rob_head_valid, input, 1 bit: the ROB head entry is ready to commit.
REQ-008 The block SHALL have port rob_head_id, input, ROB_SIZE_WIDTH bits: id of the head entry.
REQ-009 The block SHALL have port rob_head_kind, input, 2 bits: 0=reg-writing (ALU/load), 1=store, 2=branch, 3=jump.
REQ-010 The block SHALL have ports rob_head_rd (input, REG_CNT_WIDTH bits) and rob_head_val (input, XLEN bits): destination register and result.
REQ-011 The block SHALL have ports rob_head_mispredict (input, 1 bit) and rob_head_target_pc (input, XLEN bits): misprediction flag and correct PC.
REQ-012 The block SHALL have port lsb_store_done, input, 1 bit: the LSB has completed the requested store.
REQ-013 The block SHALL have port commit_pop, output, 1 bit, combinational: the ROB dequeues its head this cycle.
REQ-014 The block SHALL have ports rf_wr_en (output, 1 bit), rf_wr_rd (output, REG_CNT_WIDTH bits), rf_wr_val (output, XLEN bits) and rf_wr_id (output, ROB_SIZE_WIDTH bits), all registered: register-file write port.
REQ-015 The block SHALL have port store_commit_req, output, 1 bit, registered: level request to the LSB.
REQ-016 The block SHALL have ports flush (output, 1 bit) and flush_pc (output, XLEN bits), both registered: pipeline flush pulse and restart PC.
REQ-017 The block SHALL have ports commit_count (output, 32 bits) and busy (output, 1 bit): retired-instruction counter, and busy=1 whenever the state is not RUN.

Function
REQ-018 The state machine SHALL have states RUN, WAIT_STORE, DRAIN and FLUSH.
REQ-019 commit_pop SHALL be 1 only in the two cases below:
- in RUN with rob_head_valid=1, stall=0 and kind!=1;
- in WAIT_STORE with lsb_store_done=1.
REQ-020 On a RUN accept of kind 0 or 3, the cycle after the accept SHALL have:
- rf_wr_en=1 if rd!=0, otherwise 0;
- rf_wr_rd, rf_wr_val and rf_wr_id set to the accepted head's rd, val and id.
REQ-021 On a RUN accept of kind 2, the block SHALL keep rf_wr_en=0.
REQ-022 rf_wr_en SHALL be a one-cycle pulse per accepted instruction.
REQ-023 In RUN, a head of kind 1 (with stall=0) SHALL move the state to WAIT_STORE and set store_commit_req=1 from the next cycle.
REQ-024 store_commit_req SHALL stay high until lsb_store_done is sampled high.
REQ-025 When lsb_store_done is sampled high in WAIT_STORE, the block SHALL, in that same cycle:
- assert commit_pop;
- clear store_commit_req at the edge;
- return to RUN.
REQ-026 stall SHALL NOT cancel WAIT_STORE.
REQ-027 lsb_store_done outside WAIT_STORE SHALL be ignored.
REQ-028 An accept with rob_head_mispredict=1 and kind 2 or 3 SHALL enter DRAIN; the kind 3 register write (REQ-020) is issued during DRAIN.
REQ-029 DRAIN SHALL last one cycle, then go to FLUSH.
REQ-030 In the FLUSH cycle, flush=1 and flush_pc=the captured target_pc; FLUSH then returns to RUN.
REQ-031 flush SHALL be a one-cycle pulse.
REQ-032 The register write SHALL precise flush by exactly one cycle, since the register file drops writes while flush is high.
REQ-033 In DRAIN and FLUSH, commit_pop SHALL be 0 regardless of rob_head_valid.
REQ-034 Mispredict on kind 0 or 1 SHALL be ignored.
REQ-035 Throughput: back-to-back non-store, non-mispredict heads SHALL commit one per cycle with no bubble.
REQ-036 commit_count SHALL increment by 1 on every cycle where commit_pop=1, and wrap modulo 2^32.
REQ-037 stall=1 in RUN SHALL hold all state; rf_wr_en and flush SHALL still deassert after their single pulse cycle.

Reset
REQ-038 While rst_n=0, the following SHALL all be 0, independent of clk: state=RUN, rf_wr_en, rf_wr_rd, rf_wr_val, rf_wr_id, store_commit_req, flush, flush_pc, commit_count, busy.
REQ-039 While rst_n=0, commit_pop SHALL be 0.
REQ-040 Reset asserted in WAIT_STORE, DRAIN or FLUSH SHALL abort the operation with no flush pulse and no register write afterwards.

Verification
REQ-041 The bench SHALL cover back-to-back writes: 3 kind-0 heads (rd=1,2,3; val=10,20,30) on consecutive cycles -> commit_pop high 3 cycles, 3 rf_wr_en pulses in order one cycle later, commit_count=3.
REQ-042 The bench SHALL cover rd=0: kind-0 head with rd=0 -> commit_pop=1, rf_wr_en stays 0, commit_count increments.
REQ-043 The bench SHALL cover a store: kind-1 head, lsb_store_done after 4 cycles -> store_commit_req high 4 cycles, commit_pop exactly in the done cycle, no rf write, busy=1 throughout.
REQ-044 The bench SHALL cover a mispredicted jump: kind-3 head, rd=5, val=0x104, mispredict=1, target=0x200 -> rf write (rd 5, 0x104) next cycle, flush=1 with flush_pc=0x200 the cycle after, commit_pop=0 in both, RUN afterwards.
REQ-045 The bench SHALL cover stall: stall=1 with a valid kind-0 head -> commit_pop=0 and no state change; release -> commit next cycle.
REQ-046 The bench SHALL cover reset mid-store: rst_n low while in WAIT_STORE -> all outputs 0 immediately, state RUN after release.
